// File: rtl/stage_counter_if.sv
// Bundle of the stage sequencer's control inputs and decoded stage outputs.
// master = control unit side, slave = the sequencer itself.
interface stage_counter_if #(
  parameter int WIDTH       = 3,
  parameter int N_STAGES    = 5,
  parameter int ROUND_WIDTH = 16
) ();
  logic                   en;
  logic                   restart;
  logic [WIDTH-1:0]       out;
  logic [N_STAGES-1:0]    stage_onehot;
  logic                   first_o;
  logic                   last_o;
  logic                   wrap_o;
  logic [ROUND_WIDTH-1:0] round_count;

  modport master (
    output en, restart,
    input  out, stage_onehot, first_o, last_o, wrap_o, round_count
  );

  modport slave (
    input  en, restart,
    output out, stage_onehot, first_o, last_o, wrap_o, round_count
  );
endinterface

// File: rtl/stage_counter.sv
// Free-running instruction-stage sequencer: cycles FIRST_STAGE..LAST_STAGE,
// with one-hot decode, a registered wrap strobe and a completed-round counter.
module stage_counter #(
  parameter int WIDTH       = 3,
  parameter int FIRST_STAGE = 1,
  parameter int LAST_STAGE  = 5,
  parameter int ROUND_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  stage_counter_if.slave bus
);
  localparam int N_STAGES = LAST_STAGE - FIRST_STAGE + 1;
  localparam logic [WIDTH-1:0] FIRST_V = WIDTH'(FIRST_STAGE);
  localparam logic [WIDTH-1:0] LAST_V  = WIDTH'(LAST_STAGE);

  logic [WIDTH-1:0]       stage_q;
  logic                   wrap_q;
  logic [ROUND_WIDTH-1:0] round_q;
  logic                   in_range;
  logic                   at_last;
  logic [N_STAGES-1:0]    onehot;

  assign in_range = (int'(stage_q) >= FIRST_STAGE) && (int'(stage_q) <= LAST_STAGE);
  assign at_last  = (stage_q == LAST_V);

  // Priority: reset > restart > advance > stall. An out-of-range stage
  // recovers to FIRST_STAGE silently, without counting a round.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= FIRST_V;
      wrap_q  <= 1'b0;
      round_q <= '0;
    end else if (bus.restart) begin
      stage_q <= FIRST_V;
      wrap_q  <= 1'b0;
    end else if (bus.en) begin
      if (!in_range) begin
        stage_q <= FIRST_V;
        wrap_q  <= 1'b0;
      end else if (at_last) begin
        stage_q <= FIRST_V;
        wrap_q  <= 1'b1;
        round_q <= round_q + ROUND_WIDTH'(1);
      end else begin
        stage_q <= stage_q + WIDTH'(1);
        wrap_q  <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (int'(stage_q) == FIRST_STAGE + i) onehot[i] = 1'b1;
    end
  end

  assign bus.out          = stage_q;
  assign bus.stage_onehot = onehot;
  assign bus.first_o      = (stage_q == FIRST_V);
  assign bus.last_o       = at_last;
  assign bus.wrap_o       = wrap_q;
  assign bus.round_count  = round_q;
endmodule

// File: tb/tb_stage_counter.sv
// Bench for stage_counter: three parameterisations driven by shared stimulus,
// each checked every cycle against a stage-position model, plus literal pins.
module tb_stage_counter;
  localparam int EW = 8 + 8 + 3 + 16;
  localparam int NDUT = 3;
  localparam int F_ARR [NDUT] = '{1, 2, 3};
  localparam int L_ARR [NDUT] = '{5, 6, 3};
  localparam int RW_ARR[NDUT] = '{16, 2, 16};

  logic clk;
  logic reset;
  logic restart;
  logic en;

  int vectors;
  int miscompares;

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  stage_counter_if #(.WIDTH(3), .N_STAGES(5), .ROUND_WIDTH(16)) b0 ();
  stage_counter_if #(.WIDTH(3), .N_STAGES(5), .ROUND_WIDTH(2))  b1 ();
  stage_counter_if #(.WIDTH(3), .N_STAGES(1), .ROUND_WIDTH(16)) b2 ();

  assign b0.en = en;  assign b0.restart = restart;
  assign b1.en = en;  assign b1.restart = restart;
  assign b2.en = en;  assign b2.restart = restart;

  stage_counter #(.WIDTH(3), .FIRST_STAGE(1), .LAST_STAGE(5), .ROUND_WIDTH(16))
    dut0 (.clk(clk), .reset(reset), .bus(b0));
  stage_counter #(.WIDTH(3), .FIRST_STAGE(2), .LAST_STAGE(6), .ROUND_WIDTH(2))
    dut1 (.clk(clk), .reset(reset), .bus(b1));
  stage_counter #(.WIDTH(3), .FIRST_STAGE(3), .LAST_STAGE(3), .ROUND_WIDTH(16))
    dut2 (.clk(clk), .reset(reset), .bus(b2));

  // ---------------- behavioural model ----------------
  // Each counter is a position 0..N-1 within its round; out = FIRST + position.
  int pos    [NDUT];
  int rounds [NDUT];
  bit wrap_m [NDUT];
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];

  task automatic model_step(input logic r, input logic rs, input logic e);
    for (int k = 0; k < NDUT; k++) begin
      int n;
      logic [EW-1:0] x;
      n = L_ARR[k] - F_ARR[k] + 1;
      if (!r) begin
        pos[k] = 0; wrap_m[k] = 1'b0; rounds[k] = 0;
      end else if (rs) begin
        pos[k] = 0; wrap_m[k] = 1'b0;
      end else if (e) begin
        pos[k] = (pos[k] + 1) % n;
        wrap_m[k] = (pos[k] == 0);
        if (pos[k] == 0) rounds[k] = (rounds[k] + 1) % (1 << RW_ARR[k]);
      end else begin
        wrap_m[k] = 1'b0;
      end
      x = {8'(F_ARR[k] + pos[k]), 8'(1 << pos[k]), (pos[k] == 0), (pos[k] == n - 1),
           wrap_m[k], 16'(rounds[k])};
      case (k)
        0: exp_q0.push_back(x);
        1: exp_q1.push_back(x);
        default: exp_q2.push_back(x);
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_cmp(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h expected %h (out,onehot,first,last,wrap,rounds)",
               name, $time, act, exp);
    end
  endtask

  task automatic scoreboard_check();
    logic [EW-1:0] a;
    a = {8'(b0.out), 8'(b0.stage_onehot), b0.first_o, b0.last_o, b0.wrap_o, 16'(b0.round_count)};
    sb_cmp("dut0_outputs", a, exp_q0.pop_front());
    a = {8'(b1.out), 8'(b1.stage_onehot), b1.first_o, b1.last_o, b1.wrap_o, 16'(b1.round_count)};
    sb_cmp("dut1_outputs", a, exp_q1.pop_front());
    a = {8'(b2.out), 8'(b2.stage_onehot), b2.first_o, b2.last_o, b2.wrap_o, 16'(b2.round_count)};
    sb_cmp("dut2_outputs", a, exp_q2.pop_front());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 2 time units after an edge; outputs are checked there too.
  task automatic cycle(input logic r, input logic rs, input logic e);
    reset = r; restart = rs; en = e;
    model_step(r, rs, e);
    @(posedge clk);
    #2;
    scoreboard_check();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; restart = 1'b0; en = 1'b1;

    // Reset held two cycles
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("reset_out", 32'(b0.out), 32'd1);
    chk("reset_round", 32'(b0.round_count), 32'd0);
    chk("reset_wrap", 32'(b0.wrap_o), 32'd0);
    chk("reset_dut1_out", 32'(b1.out), 32'd2);

    // Ten full rounds: 2,3,4,5,1 each; dut1 rounds count modulo 4
    for (int r = 1; r <= 10; r++) begin
      for (int s = 0; s < 5; s++) begin
        cycle(1'b1, 1'b0, 1'b1);
        chk("seq_out", 32'(b0.out), (s == 4) ? 32'd1 : 32'(s + 2));
      end
      chk("round_count", 32'(b0.round_count), 32'(r));
      chk("wrap_pulse", 32'(b0.wrap_o), 32'd1);
      chk("dut1_round_mod4", 32'(b1.round_count), 32'(r % 4));
      chk("dut1_onehot0", 32'(b1.stage_onehot[0]), 32'd1);
    end
    cycle(1'b1, 1'b0, 1'b1);
    chk("wrap_one_cycle", 32'(b0.wrap_o), 32'd0);
    chk("degen_out", 32'(b2.out), 32'd3);
    chk("degen_wrap", 32'(b2.wrap_o), 32'd1);
    chk("degen_first_last", {30'd0, b2.first_o, b2.last_o}, 32'd3);

    // Stall at out=3
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk("stall_out", 32'(b0.out), 32'd3);
      chk("stall_onehot", 32'(b0.stage_onehot), 32'b00100);
      chk("stall_last", 32'(b0.last_o), 32'd0);
      chk("stall_wrap", 32'(b0.wrap_o), 32'd0);
    end
    chk("degen_stall_wrap", 32'(b2.wrap_o), 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("resume_out", 32'(b0.out), 32'd4);

    // Restart mid-sequence keeps round count
    cycle(1'b1, 1'b1, 1'b1);
    chk("restart_out", 32'(b0.out), 32'd1);
    chk("restart_round", 32'(b0.round_count), 32'd10);
    chk("restart_wrap", 32'(b0.wrap_o), 32'd0);

    // Reset beats restart; reset during stall
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("prio_out", 32'(b0.out), 32'd1);
    chk("prio_round", 32'(b0.round_count), 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("reset_stall_out", 32'(b0.out), 32'd1);

    // Randomised stimulus, model-checked every cycle
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
